// File: rtl/btn_conditioner.sv
// Push-button front-end: per-bit 2-flop synchroniser, debounce FSM and
// optional auto-repeat on the direction buttons. Outputs are registered.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | level 0, input stable low
// ST_ARM    | level 0, input high, counting towards acceptance
// ST_HELD   | level 1, counting the initial repeat delay (or saturated)
// ST_REPEAT | level 1, auto-repeat running at REPEAT_RATE
// ST_DISARM | level 1, input low, counting towards release
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DLY   = 50000000,
    parameter int REPEAT_RATE  = 15000000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    input  logic       rpt_en,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_release
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HELD,
        ST_REPEAT,
        ST_DISARM
    } state_e;

    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_TC = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0]       meta_q, meta_d;
    logic [4:0]       sync_q, sync_d;
    state_e           state_q [5];
    state_e           state_d [5];
    logic [CNT_W-1:0] cnt_q   [5];
    logic [CNT_W-1:0] cnt_d   [5];
    logic [4:0]       level_q, level_d;
    logic [4:0]       press_q, press_d;
    logic [4:0]       release_q, release_d;

    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
    end

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 5; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (sync_q[i]) begin
                        state_d[i] = ST_ARM;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                ST_ARM: begin
                    if (!sync_q[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_TC) begin
                        state_d[i] = ST_HELD;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!sync_q[i]) begin
                        state_d[i] = ST_DISARM;
                        cnt_d[i]   = CNT_ONE;
                    end else if ((i != 0) && rpt_en && (cnt_q[i] == DLY_TC)) begin
                        state_d[i] = ST_REPEAT;
                        press_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != DLY_TC) begin
                        // Saturates at the delay terminal count so a later rpt_en fires at once
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!sync_q[i]) begin
                        state_d[i] = ST_DISARM;
                        cnt_d[i]   = CNT_ONE;
                    end else if (!rpt_en) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = DLY_TC;
                    end else if (cnt_q[i] == RATE_TC) begin
                        press_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_DISARM: begin
                    if (sync_q[i]) begin
                        state_d[i] = ST_HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DEB_TC) begin
                        state_d[i]   = ST_IDLE;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                        cnt_d[i]     = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    level_d[i] = 1'b0;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed timing scenarios plus a randomized
// run, all checked cycle by cycle against an elapsed-time reference model.
module tb_btn_conditioner;

    localparam int DEB  = 4;
    localparam int DLY  = 10;
    localparam int RATE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn_raw = '0;
    logic       rpt_en = 1'b0;
    logic [4:0] btn_level, btn_press, btn_release;

    btn_conditioner #(
        .DEBOUNCE_CYC(DEB),
        .REPEAT_DLY  (DLY),
        .REPEAT_RATE (RATE),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .rpt_en     (rpt_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: time the synchronised input has disagreed with the
    // accepted level, and time elapsed since the last press or restart
    logic [4:0] m_sync1, m_sync2;
    logic [4:0] m_level, m_press, m_release;
    int         m_run     [5];
    int         m_elapsed [5];
    bit         m_rep     [5];

    int          cyc;
    logic [63:0] press_log [5];
    logic [63:0] rel_log   [5];
    logic [63:0] lvl_log   [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic [4:0] raw, input logic ren, input logic r);
        logic [4:0] s;
        if (r) begin
            m_sync1 = '0; m_sync2 = '0;
            m_level = '0; m_press = '0; m_release = '0;
            for (int i = 0; i < 5; i++) begin
                m_run[i] = 0; m_elapsed[i] = 0; m_rep[i] = 0;
            end
            return;
        end
        s = m_sync2;
        m_sync2 = m_sync1;
        m_sync1 = raw;
        m_press = '0;
        m_release = '0;
        for (int i = 0; i < 5; i++) begin
            if (!m_level[i]) begin
                if (s[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = 1'b1; m_press[i] = 1'b1;
                        m_run[i] = 0; m_elapsed[i] = 0; m_rep[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end else if (!s[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_level[i] = 1'b0; m_release[i] = 1'b1; m_run[i] = 0;
                end
            end else if (m_run[i] != 0) begin
                m_run[i] = 0; m_elapsed[i] = 0; m_rep[i] = 0;
            end else if (i != 0 && ren) begin
                if ((!m_rep[i] && m_elapsed[i] == DLY - 1) || (m_rep[i] && m_elapsed[i] == RATE - 1)) begin
                    m_press[i] = 1'b1; m_rep[i] = 1; m_elapsed[i] = 0;
                end else begin
                    m_elapsed[i]++;
                end
            end else if (m_rep[i]) begin
                m_rep[i] = 0; m_elapsed[i] = DLY - 1;
            end else if (m_elapsed[i] < DLY - 1) begin
                m_elapsed[i]++;
            end
        end
    endtask

    task automatic step(input logic [4:0] raw, input logic ren, input logic r);
        btn_raw = raw;
        rpt_en  = ren;
        rst     = r;
        model_step(raw, ren, r);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("level", 64'(btn_level), 64'(m_level));
        chk("press", 64'(btn_press), 64'(m_press));
        chk("release", 64'(btn_release), 64'(m_release));
        if (cyc < 64) begin
            for (int i = 0; i < 5; i++) begin
                press_log[i][cyc] = btn_press[i];
                rel_log[i][cyc]   = btn_release[i];
                lvl_log[i][cyc]   = btn_level[i];
            end
        end
    endtask

    task automatic begin_scn();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            press_log[i] = '0; rel_log[i] = '0; lvl_log[i] = '0;
        end
    endtask

    task automatic repeat_scn(input bit glitch);
        begin_scn();
        for (int n = 0; n < 56; n++) begin
            logic [4:0] raw;
            raw = (n < 40 || (glitch && n == 43)) ? 5'b00100 : 5'b00000;
            step(raw, n < 23, 1'b0);
        end
    endtask

    logic [4:0] rnd_raw;
    logic       rnd_ren;
    int         flip_div;

    initial begin
        cyc = 0;
        model_step('0, 1'b0, 1'b1);

        begin_scn();
        chk("reset_level", 64'(btn_level), 64'd0);
        chk("reset_press", 64'(btn_press), 64'd0);

        // clean press on C
        for (int n = 0; n < 20; n++) step(5'b00001, 1'b1, 1'b0);
        chk("clean_press_mask", press_log[0], 64'd1 << 6);
        chk("clean_level_c5", 64'(lvl_log[0][5]), 64'd0);
        chk("clean_level_c20", 64'(lvl_log[0][20]), 64'd1);

        // bounce rejection on R
        begin_scn();
        for (int n = 0; n < 30; n++)
            step((n < 20 && (n % 4) < 2) ? 5'b00010 : 5'b00000, 1'b1, 1'b0);
        chk("bounce_press", press_log[1], 64'd0);
        chk("bounce_release", rel_log[1], 64'd0);
        chk("bounce_level", lvl_log[1], 64'd0);

        // auto-repeat on L, then release
        repeat_scn(1'b0);
        chk("rpt_press_mask", press_log[2], (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22));
        chk("rpt_level_c39", 64'(lvl_log[2][39]), 64'd1);
        chk("rel_mask", rel_log[2], 64'd1 << 46);
        chk("rel_level_c45", 64'(lvl_log[2][45]), 64'd1);
        chk("rel_level_c46", 64'(lvl_log[2][46]), 64'd0);

        // glitch during release restarts the debounce from held
        repeat_scn(1'b1);
        chk("glitch_rel_mask", rel_log[2], 64'd1 << 50);
        chk("glitch_press_mask", press_log[2], (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22));

        // simultaneous presses with mid-operation reset
        begin_scn();
        for (int n = 0; n < 20; n++) step(5'b11111, 1'b1, n == 8 || n == 9);
        chk("simul_press_c6", {59'd0, press_log[4][6], press_log[3][6], press_log[2][6], press_log[1][6], press_log[0][6]}, 64'h1f);
        chk("simul_level_c9", {59'd0, lvl_log[4][9], lvl_log[3][9], lvl_log[2][9], lvl_log[1][9], lvl_log[0][9]}, 64'd0);
        chk("simul_press_c16", {59'd0, press_log[4][16], press_log[3][16], press_log[2][16], press_log[1][16], press_log[0][16]}, 64'h1f);
        chk("simul_press_c11", {59'd0, press_log[4][11], press_log[3][11], press_log[2][11], press_log[1][11], press_log[0][11]}, 64'd0);

        // randomized run against the model
        begin_scn();
        rnd_raw  = '0;
        rnd_ren  = 1'b1;
        flip_div = 20;
        for (int n = 0; n < 4000; n++) begin
            if ((n % 60) == 0) flip_div = ($urandom_range(0, 2) == 0) ? 2 : 25;
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, flip_div - 1) == 0) rnd_raw[i] = ~rnd_raw[i];
            if ($urandom_range(0, 79) == 0) rnd_ren = ~rnd_ren;
            step(rnd_raw, rnd_ren, $urandom_range(0, 599) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
